// File: rtl/alu_pkg.sv
// alu_pkg: select encoding, data width and result record shared by the ALU core and responder.
package alu_pkg;
  localparam int DW = 32;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;
  typedef struct packed {
    logic [DW-1:0] result;
    logic          negative;
    logic          zero;
    logic          overflow;
    logic          carry;
  } alu_res_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational 32-bit ALU producing result and N/Z/V/C flags.
module alu_core
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  input  logic [2:0]    sel,
  output alu_res_t      res
);
  logic [DW:0] add_s, sub_s;
  logic [DW-1:0] r;
  logic c, v;
  always_comb begin
    add_s = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    sub_s = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (sel)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: begin
        r = add_s[DW-1:0];
        c = add_s[DW];
        v = (a[DW-1] == b[DW-1]) && (add_s[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        r = sub_s[DW-1:0];
        c = sub_s[DW];
        v = (a[DW-1] != b[DW-1]) && (sub_s[DW-1] != a[DW-1]);
      end
      ALU_SLT: r = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_XOR: r = a ^ b;
      ALU_NOR: r = ~(a | b);
      default: r = a << b[4:0];
    endcase
    res.result   = r;
    res.negative = r[DW-1];
    res.zero     = (r == '0);
    res.overflow = v;
    res.carry    = c;
  end
endmodule

// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: valid/ready command intake, ALU evaluation and in-order response buffer.
module alu_cmd_responder
  import alu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic             cmd_cin,
  input  logic [2:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_overflow,
  output logic             rsp_carry,
  output logic [CNT_W-1:0] acc_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  alu_res_t core_res;
  alu_res_t mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic push, pop;

  alu_core u_core (
    .a   (cmd_a),
    .b   (cmd_b),
    .cin (cmd_cin),
    .sel (cmd_sel),
    .res (core_res)
  );

  // Ready looks only at the registered count, so a pop never frees space in the same cycle.
  assign cmd_ready = count_q < (AW+1)'(DEPTH);
  assign rsp_valid = count_q != '0;
  assign push = cmd_valid && cmd_ready;
  assign pop  = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    acc_d    = push ? acc_q + CNT_W'(1) : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      if (push) mem_q[wr_ptr_q] <= core_res;
    end
  end

  assign rsp_result   = mem_q[rd_ptr_q].result;
  assign rsp_negative = mem_q[rd_ptr_q].negative;
  assign rsp_zero     = mem_q[rd_ptr_q].zero;
  assign rsp_overflow = mem_q[rd_ptr_q].overflow;
  assign rsp_carry    = mem_q[rd_ptr_q].carry;
  assign acc_count    = acc_q;
endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb_alu_cmd_responder: directed vector table plus handshake corner-case sequences.
module tb_alu_cmd_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_cin = 1'b0;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_sel = '0;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic rsp_negative, rsp_zero, rsp_overflow, rsp_carry;
  logic [15:0] acc_count;
  int tests = 0, fails = 0;

  typedef struct {
    logic [31:0] a, b;
    logic cin;
    logic [2:0] sel;
    logic [31:0] res;
    logic n, z, v, c;
  } vec_t;
  vec_t vt [15];

  alu_cmd_responder #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_negative(rsp_negative), .rsp_zero(rsp_zero),
    .rsp_overflow(rsp_overflow), .rsp_carry(rsp_carry),
    .acc_count(acc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    cmd_valid = 1'b1;
    cmd_a = t.a;
    cmd_b = t.b;
    cmd_cin = t.cin;
    cmd_sel = t.sel;
  endtask

  task automatic check_rsp(input string name, input vec_t t);
    check({name, " valid"}, 64'(rsp_valid), 64'd1);
    check({name, " result"}, 64'(rsp_result), 64'(t.res));
    check({name, " flags"}, 64'({rsp_negative, rsp_zero, rsp_overflow, rsp_carry}),
          64'({t.n, t.z, t.v, t.c}));
  endtask

  task automatic do_reset();
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset acc_count", 64'(acc_count), 64'd0);
    check("reset rsp_data", 64'({rsp_result, rsp_negative, rsp_zero, rsp_overflow, rsp_carry}), 64'd0);
  endtask

  vec_t bp [3];

  initial begin
    vt[0]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b000, 32'h02502181, 0, 0, 0, 0};
    vt[1]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b001, 32'h4773378B, 0, 0, 0, 0};
    vt[2]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b010, 32'h49C3590C, 0, 0, 0, 0};
    vt[3]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b011, 32'hBB22EA06, 1, 0, 0, 0};
    vt[4]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b100, 32'h00000001, 0, 0, 0, 0};
    vt[5]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b101, 32'h4523160A, 0, 0, 0, 0};
    vt[6]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b110, 32'hB88CC874, 1, 0, 0, 0};
    vt[7]  = '{32'h02732189, 32'h47503783, 1'b0, 3'b111, 32'h13990C48, 0, 0, 0, 0};
    vt[8]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 3'b010, 32'h80000000, 1, 0, 1, 0};
    vt[9]  = '{32'h12345678, 32'h12345678, 1'b0, 3'b011, 32'h00000000, 0, 1, 0, 1};
    vt[10] = '{32'h02732189, 32'h47503783, 1'b1, 3'b010, 32'h49C3590D, 0, 0, 0, 0};
    vt[11] = '{32'h02732189, 32'h47503783, 1'b1, 3'b011, 32'hBB22EA06, 1, 0, 0, 0};
    vt[12] = '{32'h80000000, 32'h00000001, 1'b0, 3'b011, 32'h7FFFFFFF, 0, 0, 1, 1};
    vt[13] = '{32'h00000001, 32'h0000001F, 1'b0, 3'b111, 32'h80000000, 1, 0, 0, 0};
    vt[14] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 32'h00000001, 0, 0, 0, 0};
    bp[0]  = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 3'b000, 32'h00000001, 0, 0, 0, 0};
    bp[1]  = '{32'h00000002, 32'hFFFFFFFF, 1'b0, 3'b000, 32'h00000002, 0, 0, 0, 0};
    bp[2]  = '{32'h00000003, 32'hFFFFFFFF, 1'b0, 3'b000, 32'h00000003, 0, 0, 0, 0};

    do_reset();
    // One command at a time: response must appear exactly one cycle after accept.
    rsp_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check($sformatf("vec%0d cmd_ready", i), 64'(cmd_ready), 64'd1);
      drive(vt[i]);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_rsp($sformatf("vec%0d", i), vt[i]);
    end
    @(negedge clk);
    check("vec drained", 64'(rsp_valid), 64'd0);
    check("vec acc_count", 64'(acc_count), 64'd15);

    // Back-to-back sweep of all selects with rsp_ready held high.
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i > 0) check_rsp($sformatf("sweep%0d", i - 1), vt[i - 1]);
      check($sformatf("sweep%0d cmd_ready", i), 64'(cmd_ready), 64'd1);
      drive(vt[i]);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check_rsp("sweep7", vt[7]);
    @(negedge clk);
    check("sweep drained", 64'(rsp_valid), 64'd0);
    check("sweep acc_count", 64'(acc_count), 64'd8);

    // Backpressure: fill, observe stall, then drain with a simultaneous accept+pop.
    rsp_ready = 1'b0;
    drive(bp[0]);
    check("bp ready0", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    drive(bp[1]);
    check("bp ready1", 64'(cmd_ready), 64'd1);
    check_rsp("bp head1", bp[0]);
    @(negedge clk);
    drive(bp[2]);
    check("bp full ready", 64'(cmd_ready), 64'd0);
    check_rsp("bp head1 stable", bp[0]);
    @(negedge clk);
    check("bp still full", 64'(cmd_ready), 64'd0);
    check_rsp("bp head1 stable2", bp[0]);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp ready after pop", 64'(cmd_ready), 64'd1);
    check_rsp("bp head2", bp[1]);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_rsp("bp head3", bp[2]);
    check("bp same-cycle count", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    check("bp drained", 64'(rsp_valid), 64'd0);
    check("bp acc_count", 64'(acc_count), 64'd11);

    // Reset in the middle of a handshake with two entries buffered.
    rsp_ready = 1'b0;
    drive(bp[0]);
    @(negedge clk);
    drive(bp[1]);
    @(negedge clk);
    drive(bp[2]);
    check("pre-reset valid", 64'(rsp_valid), 64'd1);
    check("pre-reset full", 64'(cmd_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async rsp_valid", 64'(rsp_valid), 64'd0);
    check("async acc_count", 64'(acc_count), 64'd0);
    check("async cmd_ready", 64'(cmd_ready), 64'd1);
    check("async rsp_result", 64'(rsp_result), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post-reset idle%0d", i), 64'(rsp_valid), 64'd0);
      check($sformatf("post-reset ready%0d", i), 64'(cmd_ready), 64'd1);
    end
    drive(vt[9]);
    @(negedge clk);
    cmd_valid = 1'b0;
    check_rsp("post-reset fresh", vt[9]);
    @(negedge clk);
    check("post-reset drained", 64'(rsp_valid), 64'd0);
    check("post-reset acc_count", 64'(acc_count), 64'd1);

    // acc_count wraps: 2^16+1 accepts from reset leaves 1.
    do_reset();
    rsp_ready = 1'b1;
    drive(vt[0]);
    repeat (65537) @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wrap acc_count", 64'(acc_count), 64'd1);
    @(negedge clk);
    check("wrap drained", 64'(rsp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_cmd_responder.md
# alu_cmd_responder

Command-side responder for the 32-bit ALU. Accepts operation commands (A, B, carry-in, 3-bit select) over a valid/ready handshake, evaluates them through a combinational ALU core, and returns result plus flags (negative, zero, overflow, carry-out) through a small in-order response buffer with its own valid/ready handshake. It sits between any command source (sequencer, bench driver, future datapath controller) and the consumer of ALU results, so the ALU can run under backpressure.

## Interface
- DEPTH, 2, response buffer entries; power of two, 2..16
- CNT_W, 16, width of the accepted-command counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  responder can accept a command this cycle
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_cin  in  1  carry-in, used by ADD only
- cmd_sel  in  3  operation select
- rsp_valid  out  1  head response present
- rsp_ready  in  1  consumer takes head response
- rsp_result  out  32  result
- rsp_negative  out  1  rsp_result[31]
- rsp_zero  out  1  rsp_result == 0
- rsp_overflow  out  1  signed overflow (ADD/SUB only)
- rsp_carry  out  1  carry-out (ADD/SUB only)
- acc_count  out  CNT_W  commands accepted since reset, wraps

## Operation
- Select encoding: 000 AND, 001 OR, 010 ADD (A+B+cin), 011 SUB (A+~B+1, cin ignored), 100 SLT (signed A<B gives 1 else 0), 101 XOR, 110 NOR, 111 SLL (A << B[4:0]).
- All arithmetic uses 33-bit sums. Carry = bit 32. For SUB, carry=1 means no borrow. Overflow = operands' sign bits agree (B inverted for SUB) and result sign differs.
- Logic, SLT and SLL ops: carry=0, overflow=0. Negative and zero are always derived from the result.
- Accept: cmd_valid && cmd_ready. On accept, the ALU core output and flags are written to the buffer tail and acc_count increments, wrapping to 0 after all ones.
- cmd_ready = (count < DEPTH). It depends only on registered state and has no combinational path from rsp_ready.
- rsp_valid = (count != 0). rsp_* show the head entry. Pop: rsp_valid && rsp_ready.
- Simultaneous accept and pop: count is unchanged and both pointers advance.
- When full, cmd_ready=0, so a pop in that cycle frees space only for the next cycle.
- When empty, rsp_valid=0. rsp_* data must hold the last written entry or 0, and the bench must not check it.
- Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Responses leave in strict acceptance order.
- rsp_* must remain stable while rsp_valid && !rsp_ready.

## Timing
- Reset (asynchronous assert, synchronous release): count=0, pointers=0, acc_count=0, rsp_valid=0, all rsp_* data=0, cmd_ready=1 in the first cycle after release.
- Latency: a command accepted at edge N is presented with rsp_valid=1 after edge N, one cycle later.
- Throughput: one command per cycle when rsp_ready is held high, with DEPTH>=2 and no bubbles.
- Reset asserted mid-stream: all buffered responses are discarded immediately and outputs return to reset values without waiting for a clock.

## Structure
- Shared package alu_pkg holds the select encoding constants (ALU_AND … ALU_SLL), the data width constant (32), and a packed result struct (result, negative, zero, overflow, carry).
- One sub-module, alu_core: purely combinational, inputs a, b, cin, sel, outputs the result struct.
- Top level contains the buffer storage, the pointers, the count and acc_count.

## Test plan
- A=0x02732189, B=0x47503783, cin=0, sel=010 -> result 0x49C3590C, N=0, Z=0, V=0, C=0. Same operands, sel=011 -> 0xBB22EA06, N=1, V=0, C=0.
- A=0x7FFFFFFF, B=1, sel=010 -> 0x80000000, V=1, N=1, C=0. A=B=0x12345678, sel=011 -> 0, Z=1, C=1.
- Sweep sel 000..111 with the first operand pair, rsp_ready=1 throughout -> eight responses on consecutive cycles in order, each one cycle after its accept, acc_count=8.
- Hold rsp_ready=0 and present three commands -> cmd_ready falls after 2 accepts. Then raise rsp_ready -> responses 1, 2, 3 in order, with no loss or duplication.
- With count=1, accept and pop in the same cycle -> count stays 1 and the next head is correct. Drive 2^CNT_W+1 accepts -> acc_count=1.
- Assert rst_n=0 with 2 entries buffered and mid-handshake -> rsp_valid=0 and acc_count=0 immediately. After release, cmd_ready=1 and no stale responses appear.
